// File: rtl/fault_input_qualifier_pkg.sv
// Package rpsc_pkg: shared types and constants for the fault input qualifier.
//   qual_state_t     per-channel filter state
//   DEF_*            default filter constants
//   lowest_set()     index of the lowest set bit in a vector (first-fault capture)
package rpsc_pkg;

  typedef enum logic [1:0] {IDLE, AST_WAIT, ACTIVE, REL_WAIT} qual_state_t;

  localparam int DEF_N_CH        = 8;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_ASSERT_CNT  = 16;
  localparam int DEF_RELEASE_CNT = 4;

  // Lowest set bit wins; returns 0 for an all-zero vector.
  function automatic int unsigned lowest_set(input logic [31:0] v);
    int unsigned idx;
    idx = 0;
    for (int i = 31; i >= 0; i--)
      if (v[i]) idx = unsigned'(i);
    return idx;
  endfunction

endpackage

// File: rtl/fault_input_qualifier_if.sv
// fault_input_qualifier_if: bundles the fault inputs and qualified outputs.
//   raw_in      raw asynchronous fault inputs (1 = fault)
//   blank       suppress qualification
//   ff_clear    clear the first-fault record
//   qual_out    debounced fault level per channel
//   rise_pulse  one-cycle pulse on qual_out 0->1
//   first_valid first-fault record valid
//   first_id    index of the first qualified channel
// master = stimulus side, slave = the qualifier.
interface fault_input_qualifier_if #(
  parameter int N_CH = 8
) ();
  localparam int ID_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic [N_CH-1:0] raw_in;
  logic            blank;
  logic            ff_clear;
  logic [N_CH-1:0] qual_out;
  logic [N_CH-1:0] rise_pulse;
  logic            first_valid;
  logic [ID_W-1:0] first_id;

  modport master (
    output raw_in, blank, ff_clear,
    input  qual_out, rise_pulse, first_valid, first_id
  );

  modport slave (
    input  raw_in, blank, ff_clear,
    output qual_out, rise_pulse, first_valid, first_id
  );
endinterface

// File: rtl/fault_input_qualifier_ch.sv
// fault_qual_ch: one fault channel -- synchroniser, assert/release debounce
// FSM with its counter, and a registered rise pulse.
//   clk, reset  clock, synchronous active-high reset
//   raw         asynchronous raw fault input
//   blank       force IDLE / count 0 at the next edge
//   qual        debounced level (state is ACTIVE or REL_WAIT)
//   rise        high for the single cycle qual first reads 1
module fault_qual_ch
  import rpsc_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int ASSERT_CNT  = DEF_ASSERT_CNT,
  parameter int RELEASE_CNT = DEF_RELEASE_CNT
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  input  logic blank,
  output logic qual,
  output logic rise
);
  localparam int MAX_CNT = (ASSERT_CNT > RELEASE_CNT) ? ASSERT_CNT : RELEASE_CNT;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);
  localparam logic [CNT_W-1:0] AST_TGT = CNT_W'(ASSERT_CNT);
  localparam logic [CNT_W-1:0] REL_TGT = CNT_W'(RELEASE_CNT);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   s_in;
  qual_state_t            state;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       cnt_inc;

  assign s_in    = sync[SYNC_STAGES-1];
  // cnt stays below its target while waiting, so the increment cannot wrap.
  assign cnt_inc = cnt + ONE;

  // qual and rise are registered alongside the state so that rise fires only
  // on a true 0->1 transition (REL_WAIT -> ACTIVE keeps qual high, no pulse).
  always_ff @(posedge clk) begin
    if (reset) begin
      sync  <= '0;
      state <= IDLE;
      cnt   <= '0;
      qual  <= 1'b0;
      rise  <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], raw};
      rise <= 1'b0;
      if (blank) begin
        state <= IDLE;
        cnt   <= '0;
        qual  <= 1'b0;
      end else begin
        case (state)
          IDLE: if (s_in) begin
            if (ASSERT_CNT == 1) begin
              state <= ACTIVE;
              cnt   <= '0;
              qual  <= 1'b1;
              rise  <= 1'b1;
            end else begin
              state <= AST_WAIT;
              cnt   <= ONE;
            end
          end
          AST_WAIT: begin
            if (!s_in) begin
              state <= IDLE;
              cnt   <= '0;
            end else if (cnt_inc == AST_TGT) begin
              state <= ACTIVE;
              cnt   <= '0;
              qual  <= 1'b1;
              rise  <= 1'b1;
            end else begin
              cnt <= cnt_inc;
            end
          end
          ACTIVE: if (!s_in) begin
            if (RELEASE_CNT == 1) begin
              state <= IDLE;
              cnt   <= '0;
              qual  <= 1'b0;
            end else begin
              state <= REL_WAIT;
              cnt   <= ONE;
            end
          end
          REL_WAIT: begin
            if (s_in) begin
              state <= ACTIVE;
              cnt   <= '0;
            end else if (cnt_inc == REL_TGT) begin
              state <= IDLE;
              cnt   <= '0;
              qual  <= 1'b0;
            end else begin
              cnt <= cnt_inc;
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
            qual  <= 1'b0;
          end
        endcase
      end
    end
  end
endmodule

// File: rtl/fault_input_qualifier.sv
// fault_input_qualifier: conditions raw comparator/alarm inputs for the
// hold-error flip-flops. N_CH independent fault_qual_ch instances plus an
// optional first-fault recorder.
//   clk, reset  clock, synchronous active-high reset
//   bus         fault_input_qualifier_if.slave (raw_in, blank, ff_clear in;
//               qual_out, rise_pulse, first_valid, first_id out)
// Build option: RPSC_FIRST_FAULT_EN enables first_valid/first_id capture;
// without it those outputs are tied 0 and ff_clear is ignored.
module fault_input_qualifier
  import rpsc_pkg::*;
#(
  parameter int N_CH        = DEF_N_CH,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int ASSERT_CNT  = DEF_ASSERT_CNT,
  parameter int RELEASE_CNT = DEF_RELEASE_CNT
) (
  input logic               clk,
  input logic               reset,
  fault_input_qualifier_if.slave bus
);
  localparam int ID_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic [N_CH-1:0] qual;
  logic [N_CH-1:0] rise;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    fault_qual_ch #(
      .SYNC_STAGES (SYNC_STAGES),
      .ASSERT_CNT  (ASSERT_CNT),
      .RELEASE_CNT (RELEASE_CNT)
    ) u_ch (
      .clk   (clk),
      .reset (reset),
      .raw   (bus.raw_in[g]),
      .blank (bus.blank),
      .qual  (qual[g]),
      .rise  (rise[g])
    );
  end

  assign bus.qual_out   = qual;
  assign bus.rise_pulse = rise;

`ifdef RPSC_FIRST_FAULT_EN
  logic            fv;
  logic [ID_W-1:0] fid;

  // Capture wins over clear when both land in the same cycle, so a fault
  // arriving together with ff_clear becomes the new first fault.
  always_ff @(posedge clk) begin
    if (reset) begin
      fv  <= 1'b0;
      fid <= '0;
    end else if ((|rise) && (!fv || bus.ff_clear)) begin
      fv  <= 1'b1;
      fid <= ID_W'(lowest_set(32'(rise)));
    end else if (bus.ff_clear) begin
      fv <= 1'b0;
    end
  end

  assign bus.first_valid = fv;
  assign bus.first_id    = fid;
`else
  logic unused_ff_clear;
  assign unused_ff_clear = bus.ff_clear;
  assign bus.first_valid = 1'b0;
  assign bus.first_id    = '0;
`endif
endmodule
